// File: rtl/rl_step_sequencer_pkg.sv
// Shared types and default sizing for the RL step sequencer.
// The sample word is what the queue stores; the enum is the step FSM state.
package rl_seq_pkg;

  localparam int DATA_WIDTH          = 4;
  localparam int NEURON_INPUT_LAYER  = 2;
  localparam int NEURON_OUTPUT_LAYER = 2;
  localparam int COUNT               = 4;

  localparam int STATE_W = NEURON_INPUT_LAYER * DATA_WIDTH;
  localparam int LOSS_W  = COUNT * DATA_WIDTH;
  localparam int OUT_W   = NEURON_OUTPUT_LAYER * DATA_WIDTH;

  localparam int DEF_FIFO_DEPTH     = 4;
  localparam int DEF_ENABLE_CYCLES  = 10;
  localparam int DEF_TIMEOUT_CYCLES = 255;

  typedef enum logic [2:0] {IDLE, LOAD, MFWD, TFWD, TRN, RES} seq_state_t;

  typedef struct packed {
    logic [STATE_W-1:0] state;
    logic [LOSS_W-1:0]  loss;
    logic               train;
  } sample_t;

  localparam int SAMPLE_W = $bits(sample_t);

endpackage

// File: rtl/rl_step_sequencer_if.sv
// Host-side channels: sample offer (s_*) and result return (r_*).
// Both follow valid/ready: a transfer happens on a rising clk edge where valid and ready are both 1;
// valid, once raised, holds with its payload stable until that transfer.
interface rl_step_sequencer_if;
  logic                           s_valid;
  logic                           s_ready;
  logic [rl_seq_pkg::STATE_W-1:0] s_state;
  logic [rl_seq_pkg::LOSS_W-1:0]  s_loss;
  logic                           s_train;
  logic                           r_valid;
  logic                           r_ready;
  logic [rl_seq_pkg::OUT_W-1:0]   r_data;

  modport master (output s_valid, s_state, s_loss, s_train, r_ready,
                  input  s_ready, r_valid, r_data);
  modport slave  (input  s_valid, s_state, s_loss, s_train, r_ready,
                  output s_ready, r_valid, r_data);
endinterface

// File: rtl/rl_step_sequencer_fifo.sv
// Sample queue: wrap-bit pointers for full/empty, registered read data
// that appears the cycle after a pop and holds until the next pop.
module rl_sample_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_data <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop) begin
        rd_data <= mem[rd_ptr[AW-1:0]];
        rd_ptr  <= rd_ptr + PTR_ONE;
      end
    end
  end
endmodule

// File: rtl/rl_step_sequencer.sv
// Drives one load/forward/target/train/result step per queued sample into the NN wrapper,
// reacting only to rising edges of the wrapper's level done signals, with a per-wait timeout.
module rl_step_sequencer
  import rl_seq_pkg::*;
#(
  parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter int ENABLE_CYCLES  = DEF_ENABLE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic               clk,
  input  logic               rst_b,
  rl_step_sequencer_if.slave host,
  output logic [STATE_W-1:0] nn_input,
  output logic               input_enable,
  output logic               use_target,
  output logic               is_training,
  output logic [LOSS_W-1:0]  loss,
  input  logic               model_fwd_done,
  input  logic               target_fwd_done,
  input  logic               training_done,
  input  logic [OUT_W-1:0]   nn_inf_output,
  output logic               busy,
  output logic               err_timeout,
  input  logic               clr_err,
  output seq_state_t         dbg_state
);
  localparam int EW = (ENABLE_CYCLES > 1) ? $clog2(ENABLE_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [EW-1:0] EN_LAST = EW'(ENABLE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  seq_state_t       state;
  sample_t          wr_sample, cur;
  logic             full, empty, pop;
  logic [EW-1:0]    en_cnt;
  logic [TW-1:0]    wait_cnt;
  logic             md_q, td_q, tr_q;
  logic             waiting, got_edge;
  logic             r_valid_q;
  logic [OUT_W-1:0] r_data_q;

  assign wr_sample    = '{state: host.s_state, loss: host.s_loss, train: host.s_train};
  assign host.s_ready = !full;
  assign host.r_valid = r_valid_q;
  assign host.r_data  = r_data_q;
  assign pop          = (state == IDLE) && !empty;

  // The FIFO read register doubles as the current-sample register.
  rl_sample_fifo #(.WIDTH(SAMPLE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_b   (rst_b),
    .push    (host.s_valid),
    .wr_data (wr_sample),
    .pop     (pop),
    .rd_data (cur),
    .full    (full),
    .empty   (empty)
  );

  assign nn_input  = cur.state;
  assign loss      = cur.loss;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      md_q <= 1'b0;
      td_q <= 1'b0;
      tr_q <= 1'b0;
    end else begin
      md_q <= model_fwd_done;
      td_q <= target_fwd_done;
      tr_q <= training_done;
    end
  end

  always_comb begin
    waiting  = 1'b0;
    got_edge = 1'b0;
    case (state)
      MFWD:    begin waiting = 1'b1; got_edge = model_fwd_done  && !md_q; end
      TFWD:    begin waiting = 1'b1; got_edge = target_fwd_done && !td_q; end
      TRN:     begin waiting = 1'b1; got_edge = training_done   && !tr_q; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state        <= IDLE;
      en_cnt       <= '0;
      wait_cnt     <= '0;
      input_enable <= 1'b0;
      use_target   <= 1'b0;
      is_training  <= 1'b0;
      r_valid_q    <= 1'b0;
      r_data_q     <= '0;
      busy         <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      if (clr_err) err_timeout <= 1'b0;
      // A done edge in the expiry cycle takes the normal path below.
      if (waiting && !got_edge) begin
        if (wait_cnt == TO_LAST) begin
          state       <= IDLE;
          use_target  <= 1'b0;
          is_training <= 1'b0;
          busy        <= 1'b0;
          err_timeout <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + TW'(1);
        end
      end
      case (state)
        IDLE: if (!empty) begin
          state        <= LOAD;
          en_cnt       <= '0;
          input_enable <= 1'b1;
          busy         <= 1'b1;
        end
        LOAD: if (en_cnt == EN_LAST) begin
          state        <= MFWD;
          input_enable <= 1'b0;
          wait_cnt     <= '0;
        end else begin
          en_cnt <= en_cnt + EW'(1);
        end
        MFWD: if (got_edge) begin
          r_data_q <= nn_inf_output;
          wait_cnt <= '0;
          if (cur.train) begin
            state      <= TFWD;
            use_target <= 1'b1;
          end else begin
            state     <= RES;
            r_valid_q <= 1'b1;
          end
        end
        TFWD: if (got_edge) begin
          state       <= TRN;
          is_training <= 1'b1;
          wait_cnt    <= '0;
        end
        TRN: if (got_edge) begin
          state       <= RES;
          use_target  <= 1'b0;
          is_training <= 1'b0;
          r_valid_q   <= 1'b1;
        end
        RES: if (host.r_ready) begin
          state     <= IDLE;
          r_valid_q <= 1'b0;
          busy      <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          input_enable <= 1'b0;
          use_target   <= 1'b0;
          is_training  <= 1'b0;
          r_valid_q    <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rl_step_sequencer.sv
// Bench for rl_step_sequencer: emulates the NN wrapper and a host, scoreboards results.
module tb_rl_step_sequencer;
  import rl_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  rl_step_sequencer_if host_if ();
  logic [STATE_W-1:0] nn_input;
  logic               input_enable, use_target, is_training;
  logic [LOSS_W-1:0]  loss;
  logic               model_fwd_done = 1'b0;
  logic               target_fwd_done = 1'b0;
  logic               training_done = 1'b0;
  logic [OUT_W-1:0]   nn_inf_output = '0;
  logic               busy, err_timeout;
  logic               clr_err = 1'b0;
  seq_state_t         dbg_state;

  rl_step_sequencer dut (
    .clk             (clk),
    .rst_b           (rst_b),
    .host            (host_if),
    .nn_input        (nn_input),
    .input_enable    (input_enable),
    .use_target      (use_target),
    .is_training     (is_training),
    .loss            (loss),
    .model_fwd_done  (model_fwd_done),
    .target_fwd_done (target_fwd_done),
    .training_done   (training_done),
    .nn_inf_output   (nn_inf_output),
    .busy            (busy),
    .err_timeout     (err_timeout),
    .clr_err         (clr_err),
    .dbg_state       (dbg_state)
  );

  // kind: 0 normal, 1 target_fwd_done never rises, 2 training_done never rises
  typedef struct {
    logic [STATE_W-1:0] state;
    logic [LOSS_W-1:0]  loss;
    logic               train;
    int                 kind;
  } job_t;

  job_t             issue_q[$];
  logic [OUT_W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;
  int md_delay_fix = 0;
  bit hold_md = 1'b0;
  bit hold_rr = 1'b0;

  // Stand-in network: the wrapper's inference result for a given state vector.
  function automatic logic [OUT_W-1:0] fake_nn(input logic [STATE_W-1:0] s);
    return {s[7:4] ^ s[3:0], s[3:0] + 4'd3};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [STATE_W-1:0] st, input logic [LOSS_W-1:0] ls,
                      input logic tr, input int kind, output int waited);
    bit acc;
    job_t j;
    acc = 1'b0;
    waited = 0;
    host_if.s_valid = 1'b1;
    host_if.s_state = st;
    host_if.s_loss  = ls;
    host_if.s_train = tr;
    while (!acc && waited < 3000) begin
      acc = host_if.s_ready;
      step;
      if (!acc) waited++;
    end
    host_if.s_valid = 1'b0;
    check("push_accepted", acc, 1);
    if (acc) begin
      j = '{state: st, loss: ls, train: tr, kind: kind};
      issue_q.push_back(j);
      if (kind == 0) exp_q.push_back(fake_nn(st));
    end
  endtask

  task automatic drain;
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0 || issue_q.size() != 0) && n < 5000) begin
      n++;
      step;
    end
    check("drain", (busy || exp_q.size() != 0 || issue_q.size() != 0), 0);
  endtask

  // Monitor: every presented result must match the head of the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_b && host_if.r_valid) begin
        check("result_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          if (host_if.r_ready) check("r_data", host_if.r_data, exp_q.pop_front());
          else                 check("r_data_hold", host_if.r_data, exp_q[0]);
        end
      end
    end
  end

  initial begin
    host_if.r_ready = 1'b0;
    forever begin
      step;
      host_if.r_ready = hold_rr ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Wrapper emulator: follows each step and raises done levels.
  initial begin
    job_t cur;
    int   n, d;
    bit   ok;
    forever begin
      while (input_enable !== 1'b1) step;
      check("job_known", issue_q.size() != 0, 1);
      if (issue_q.size() != 0) cur = issue_q.pop_front();
      else cur = '{state: '0, loss: '0, train: 1'b0, kind: 0};
      check("nn_input", nn_input, cur.state);
      n = 0;
      while (input_enable === 1'b1 && n < 100) begin n++; step; end
      check("enable_cycles", n, DEF_ENABLE_CYCLES);
      ok = 1'b1;
      if (model_fwd_done) begin
        hold_md = 1'b0;
        repeat (20) begin if (use_target !== 1'b0) ok = 1'b0; step; end
        check("held_done_ignored", dbg_state, MFWD);
        model_fwd_done = 1'b0;
        step;
      end else begin
        d = (md_delay_fix > 0) ? md_delay_fix : $urandom_range(1, 25);
        repeat (d) begin if (use_target !== 1'b0) ok = 1'b0; step; end
      end
      nn_inf_output = fake_nn(cur.state);
      model_fwd_done = 1'b1;
      step;
      nn_inf_output = OUT_W'($urandom);
      if (!hold_md) model_fwd_done = 1'b0;
      check("mfwd_no_target", ok, 1);
      check("use_target_after_mfwd", use_target, cur.train);
      if (cur.train && cur.kind == 1) begin
        n = 0;
        while (use_target === 1'b1 && n < 1000) begin n++; step; end
        check("timeout_cycles", n, DEF_TIMEOUT_CYCLES);
        check("err_set", err_timeout, 1);
        check("no_result_after_timeout", host_if.r_valid, 0);
      end else if (cur.train) begin
        d = $urandom_range(1, 20);
        repeat (d) step;
        target_fwd_done = 1'b1;
        step;
        target_fwd_done = 1'b0;
        check("is_training", is_training, 1);
        if (cur.kind == 2) begin
          n = 0;
          while (is_training === 1'b1 && n < 1000) begin n++; step; end
        end else begin
          ok = 1'b1;
          d = $urandom_range(1, 20);
          repeat (d) begin
            if (loss !== cur.loss || use_target !== 1'b1 || is_training !== 1'b1) ok = 1'b0;
            step;
          end
          training_done = 1'b1;
          step;
          training_done = 1'b0;
          check("trn_loss_and_flags", ok, 1);
          check("trn_exit", is_training, 0);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: run still going at %0t", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    int w, n;
    logic [OUT_W-1:0] snap;
    host_if.s_valid = 1'b0;
    host_if.s_state = '0;
    host_if.s_loss  = '0;
    host_if.s_train = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_input_enable", input_enable, 0);
    check("rst_use_target", use_target, 0);
    check("rst_is_training", is_training, 0);
    check("rst_r_valid", host_if.r_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_timeout, 0);
    check("rst_s_ready", host_if.s_ready, 1);
    check("rst_outputs", {nn_input, loss, host_if.r_data}, 0);
    rst_b = 1'b1;
    step;

    // Inference step with a slow model forward.
    md_delay_fix = 30;
    push(8'h21, 16'h0000, 1'b0, 0, w);
    drain;
    md_delay_fix = 0;

    // Training step.
    push(8'h12, 16'h0005, 1'b1, 0, w);
    drain;

    // Result backpressure while the queue fills behind it.
    hold_rr = 1'b1;
    push(8'h33, 16'h00a0, 1'b0, 0, w);
    n = 0;
    while (!host_if.r_valid && n < 300) begin n++; step; end
    check("bp_r_valid_seen", host_if.r_valid, 1);
    snap = host_if.r_data;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          push(STATE_W'($urandom), LOSS_W'($urandom), 1'($urandom), 0, w);
          if (i < 4) check("queue_accept_no_wait", w, 0);
          if (i == 3) check("queue_full_s_ready", host_if.s_ready, 0);
          if (i == 4) check("fifth_waited", w > 0, 1);
        end
      end
      begin
        repeat (50) step;
        check("bp_r_data_stable", host_if.r_data, snap);
        hold_rr = 1'b0;
      end
    join
    drain;

    // Target forward never completes; then a normal step and error clear.
    push(8'h44, 16'h1234, 1'b1, 1, w);
    drain;
    check("err_after_timeout", err_timeout, 1);
    push(8'h9c, 16'h0042, 1'b1, 0, w);
    drain;
    check("err_sticky", err_timeout, 1);
    clr_err = 1'b1;
    step;
    clr_err = 1'b0;
    check("err_cleared", err_timeout, 0);

    // model_fwd_done held high across two samples.
    hold_md = 1'b1;
    push(8'h6d, 16'h0001, 1'b0, 0, w);
    push(8'hd6, 16'h0002, 1'b0, 0, w);
    drain;

    // Random traffic.
    for (int i = 0; i < 24; i++) begin
      push(STATE_W'($urandom), LOSS_W'($urandom), 1'($urandom), 0, w);
      repeat ($urandom_range(0, 8)) step;
    end
    drain;

    // Asynchronous reset in the middle of training.
    push(8'h5a, 16'hbeef, 1'b1, 2, w);
    push(8'h17, 16'h0003, 1'b0, 0, w);
    push(8'h71, 16'h0004, 1'b1, 0, w);
    n = 0;
    while (!is_training && n < 500) begin n++; step; end
    check("reached_trn", is_training, 1);
    step;
    #2;
    rst_b = 1'b0;
    #1;
    check("async_input_enable", input_enable, 0);
    check("async_use_target", use_target, 0);
    check("async_is_training", is_training, 0);
    check("async_r_valid", host_if.r_valid, 0);
    check("async_busy", busy, 0);
    check("async_outputs", {nn_input, loss, host_if.r_data}, 0);
    check("async_s_ready", host_if.s_ready, 1);
    issue_q.delete();
    exp_q.delete();
    step;
    step;
    rst_b = 1'b1;
    repeat (5) step;
    check("fifo_empty_after_reset", busy, 0);
    check("idle_after_reset", dbg_state, IDLE);
    push(8'h3e, 16'h0007, 1'b1, 0, w);
    drain;

    check("exp_q_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
